// File: rtl/uart_sb_pkg.sv
// Shared types and helpers for the UART loopback scoreboard.
package uart_sb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } sb_state_t;

    // Width of an occupancy count that can represent 0..depth inclusive.
    function automatic int sb_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

`ifdef UART_SB_REPORT
    localparam string REPORT_FMT = "Test_%0d: TX 0x%h RX 0x%h %s";
`endif

endpackage

// File: rtl/uart_sb_fifo.sv
// Synchronous FIFO holding outstanding TX words; wrap-around pointers one bit
// wider than the address so full and empty are told apart by the extra bit.
module uart_sb_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_aresetn,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (i_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        // NOTE: state registers use non-blocking assignment so all flops sample the same pre-edge values.
        if (!i_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end

    assign o_head  = mem_q[rd_ptr_q[AW-1:0]];
    assign o_level = wr_ptr_q - rd_ptr_q;
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    assign o_empty = (o_level == '0);

endmodule

// File: rtl/uart_scoreboard.sv
// In-order TX/RX scoreboard: queues transmitted words, compares each received
// word with the oldest one, and keeps counters, sticky errors and a stall timer.
module uart_scoreboard
    import uart_sb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 0,
    localparam int LVL_W  = sb_level_w(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_aresetn,
    input  logic              i_clear,
    input  logic              i_tx_start,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_rx_done,
    input  logic [DATA_W-1:0] i_rx_data,
    output logic              o_match,
    output logic              o_mismatch,
    output logic [DATA_W-1:0] o_exp_data,
    output logic [DATA_W-1:0] o_got_data,
    output logic [CNT_W-1:0]  o_pass_cnt,
    output logic [CNT_W-1:0]  o_fail_cnt,
    output logic [LVL_W-1:0]  o_pending,
    output logic              o_err_overflow,
    output logic              o_err_orphan,
    output logic              o_err_timeout,
    output logic [1:0]        o_state
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [DATA_W-1:0] head;
    logic [LVL_W-1:0]  level, level_nxt;
    logic              full, empty;
    logic              pop, push, bypass, cmp_valid;
    logic [DATA_W-1:0] cmp_exp;

    logic              match_q, match_d, mismatch_q, mismatch_d;
    logic [DATA_W-1:0] exp_q, exp_d, got_q, got_d;
    logic [CNT_W-1:0]  pass_q, pass_d, fail_q, fail_d;
    logic              ovf_q, ovf_d, orphan_q, orphan_d, tmo_q, tmo_d;
    sb_state_t         state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    uart_sb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .i_clk     (i_clk),
        .i_aresetn (i_aresetn),
        .i_clear   (i_clear),
        .i_push    (push),
        .i_pop     (pop),
        .i_data    (i_tx_data),
        .o_head    (head),
        .o_level   (level),
        .o_full    (full),
        .o_empty   (empty)
    );

    // An RX against an empty queue with a same-cycle TX compares against that TX directly.
    always_comb begin
        pop       = i_rx_done && !empty;
        bypass    = i_rx_done && empty && i_tx_start;
        push      = i_tx_start && !bypass && (!full || pop);
        cmp_valid = pop || bypass;
        cmp_exp   = pop ? head : i_tx_data;
        level_nxt = level + LVL_W'(push) - LVL_W'(pop);
    end

    always_comb begin
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        exp_d      = exp_q;
        got_d      = got_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ovf_d      = ovf_q || (i_tx_start && full && !pop);
        orphan_d   = orphan_q || (i_rx_done && empty && !i_tx_start);
        tmo_d      = tmo_q;
        state_d    = state_q;
        timer_d    = timer_q;

        if (cmp_valid) begin
            exp_d = cmp_exp;
            got_d = i_rx_data;
            if (cmp_exp == i_rx_data) begin
                match_d = 1'b1;
                if (pass_q != '1) pass_d = pass_q + 1'b1;
            end else begin
                mismatch_d = 1'b1;
                if (fail_q != '1) fail_d = fail_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (push) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_rx_done) begin
                    timer_d = '0;
                    if (level_nxt == '0) state_d = ST_IDLE;
                end else if (TIMEOUT != 0 && timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = ST_STALL;
                    tmo_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STALL: begin
                if (i_rx_done) begin
                    timer_d = '0;
                    state_d = (level_nxt == '0) ? ST_IDLE : ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_clear) begin
            match_d    = 1'b0;
            mismatch_d = 1'b0;
            exp_d      = '0;
            got_d      = '0;
            pass_d     = '0;
            fail_d     = '0;
            ovf_d      = 1'b0;
            orphan_d   = 1'b0;
            tmo_d      = 1'b0;
            state_d    = ST_IDLE;
            timer_d    = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            exp_q      <= '0;
            got_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            ovf_q      <= 1'b0;
            orphan_q   <= 1'b0;
            tmo_q      <= 1'b0;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
        end else begin
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            exp_q      <= exp_d;
            got_q      <= got_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ovf_q      <= ovf_d;
            orphan_q   <= orphan_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
        end
    end

    assign o_match        = match_q;
    assign o_mismatch     = mismatch_q;
    assign o_exp_data     = exp_q;
    assign o_got_data     = got_q;
    assign o_pass_cnt     = pass_q;
    assign o_fail_cnt     = fail_q;
    assign o_pending      = level;
    assign o_err_overflow = ovf_q;
    assign o_err_orphan   = orphan_q;
    assign o_err_timeout  = tmo_q;
    assign o_state        = state_q;

`ifdef UART_SB_REPORT
    // Per-comparison log line; compiled in only when the report macro is defined.
    int unsigned report_n = 0;
    always @(posedge i_clk) begin
        if (i_aresetn && cmp_valid && !i_clear) begin
            report_n++;
            $display(REPORT_FMT, report_n, cmp_exp, i_rx_data,
                     (cmp_exp == i_rx_data) ? "PASS" : "FAIL");
        end
    end
`endif

endmodule

// File: tb/tb_uart_scoreboard.sv
// Directed bench for uart_scoreboard: stimulus queues expected results, a
// monitor pops and compares them whenever a result pulse appears.
module tb_uart_scoreboard;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 100;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic              clear = 1'b0;
    logic              tx_start = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              rx_done = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              o_match, o_mismatch;
    logic [DATA_W-1:0] o_exp_data, o_got_data;
    logic [CNT_W-1:0]  o_pass_cnt, o_fail_cnt;
    logic [LVL_W-1:0]  o_pending;
    logic              o_err_overflow, o_err_orphan, o_err_timeout;
    logic [1:0]        o_state;

    always #5 clk = ~clk;

    uart_scoreboard #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk          (clk),
        .i_aresetn      (aresetn),
        .i_clear        (clear),
        .i_tx_start     (tx_start),
        .i_tx_data      (tx_data),
        .i_rx_done      (rx_done),
        .i_rx_data      (rx_data),
        .o_match        (o_match),
        .o_mismatch     (o_mismatch),
        .o_exp_data     (o_exp_data),
        .o_got_data     (o_got_data),
        .o_pass_cnt     (o_pass_cnt),
        .o_fail_cnt     (o_fail_cnt),
        .o_pending      (o_pending),
        .o_err_overflow (o_err_overflow),
        .o_err_orphan   (o_err_orphan),
        .o_err_timeout  (o_err_timeout),
        .o_state        (o_state)
    );

    typedef struct packed {
        logic [DATA_W-1:0] exp;
        logic [DATA_W-1:0] got;
        logic              is_match;
    } result_t;

    result_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual === required) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, actual, required);
    endtask

    task automatic expect_cmp(input logic [DATA_W-1:0] exp, input logic [DATA_W-1:0] got, input logic is_match);
        sb_q.push_back('{exp: exp, got: got, is_match: is_match});
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic tx, input logic [DATA_W-1:0] txd,
                         input logic rx, input logic [DATA_W-1:0] rxd);
        tx_start = tx;
        tx_data  = txd;
        rx_done  = rx;
        rx_data  = rxd;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        rx_done  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_match"},    o_match,        0);
        check({tag, "_mismatch"}, o_mismatch,     0);
        check({tag, "_exp"},      o_exp_data,     0);
        check({tag, "_got"},      o_got_data,     0);
        check({tag, "_pass"},     o_pass_cnt,     0);
        check({tag, "_fail"},     o_fail_cnt,     0);
        check({tag, "_pending"},  o_pending,      0);
        check({tag, "_ovf"},      o_err_overflow, 0);
        check({tag, "_orphan"},   o_err_orphan,   0);
        check({tag, "_timeout"},  o_err_timeout,  0);
        check({tag, "_state"},    o_state,        0);
    endtask

    // Monitor: every result pulse must correspond to the oldest queued expectation.
    always @(negedge clk) begin
        result_t r;
        if (aresetn && (o_match || o_mismatch)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, o_match, o_mismatch}, 0);
            end else begin
                r = sb_q.pop_front();
                check("result_kind", {30'd0, o_match, o_mismatch}, r.is_match ? 32'd2 : 32'd1);
                check("result_exp",  o_exp_data, r.exp);
                check("result_got",  o_got_data, r.got);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // In-order matches
        drive(1'b1, 8'h55, 1'b0, '0);
        drive(1'b1, 8'hA3, 1'b0, '0);
        drive(1'b1, 8'h00, 1'b0, '0);
        check("inorder_pending3", o_pending, 3);
        check("inorder_state_wait", o_state, 1);
        expect_cmp(8'h55, 8'h55, 1'b1); drive(1'b0, '0, 1'b1, 8'h55);
        expect_cmp(8'hA3, 8'hA3, 1'b1); drive(1'b0, '0, 1'b1, 8'hA3);
        expect_cmp(8'h00, 8'h00, 1'b1); drive(1'b0, '0, 1'b1, 8'h00);
        check("inorder_pass", o_pass_cnt, 3);
        check("inorder_fail", o_fail_cnt, 0);
        check("inorder_pending0", o_pending, 0);
        check("inorder_state_idle", o_state, 0);
        do_clear();
        check("clear_pass", o_pass_cnt, 0);

        // Mismatch
        drive(1'b1, 8'h3C, 1'b0, '0);
        expect_cmp(8'h3C, 8'h3D, 1'b0);
        drive(1'b0, '0, 1'b1, 8'h3D);
        check("mis_pulse", o_mismatch, 1);
        check("mis_exp", o_exp_data, 8'h3C);
        check("mis_got", o_got_data, 8'h3D);
        check("mis_fail_cnt", o_fail_cnt, 1);
        idle(1);
        check("mis_pulse_width", o_mismatch, 0);
        check("mis_got_held", o_got_data, 8'h3D);
        do_clear();

        // Full queue, fifth push dropped; four matches saturate a 2-bit counter
        drive(1'b1, 8'h11, 1'b0, '0);
        drive(1'b1, 8'h22, 1'b0, '0);
        drive(1'b1, 8'h33, 1'b0, '0);
        drive(1'b1, 8'h44, 1'b0, '0);
        check("full_pending4", o_pending, 4);
        check("full_no_ovf_yet", o_err_overflow, 0);
        drive(1'b1, 8'h55, 1'b0, '0);
        check("full_ovf", o_err_overflow, 1);
        check("full_pending_stays4", o_pending, 4);
        expect_cmp(8'h11, 8'h11, 1'b1); drive(1'b0, '0, 1'b1, 8'h11);
        expect_cmp(8'h22, 8'h22, 1'b1); drive(1'b0, '0, 1'b1, 8'h22);
        expect_cmp(8'h33, 8'h33, 1'b1); drive(1'b0, '0, 1'b1, 8'h33);
        expect_cmp(8'h44, 8'h44, 1'b1); drive(1'b0, '0, 1'b1, 8'h44);
        check("sat_pass", o_pass_cnt, 3);
        check("full_drained", o_pending, 0);
        check("full_state_idle", o_state, 0);
        do_clear();

        // Full queue with a same-cycle pop: push accepted
        drive(1'b1, 8'hA1, 1'b0, '0);
        drive(1'b1, 8'hA2, 1'b0, '0);
        drive(1'b1, 8'hA3, 1'b0, '0);
        drive(1'b1, 8'hA4, 1'b0, '0);
        expect_cmp(8'hA1, 8'hA1, 1'b1);
        drive(1'b1, 8'hA5, 1'b1, 8'hA1);
        check("fullpop_no_ovf", o_err_overflow, 0);
        check("fullpop_pending4", o_pending, 4);
        expect_cmp(8'hA2, 8'hA2, 1'b1); drive(1'b0, '0, 1'b1, 8'hA2);
        expect_cmp(8'hA3, 8'hA3, 1'b1); drive(1'b0, '0, 1'b1, 8'hA3);
        expect_cmp(8'hA4, 8'hA4, 1'b1); drive(1'b0, '0, 1'b1, 8'hA4);
        expect_cmp(8'hA5, 8'hA5, 1'b1); drive(1'b0, '0, 1'b1, 8'hA5);
        check("fullpop_pending0", o_pending, 0);
        check("fullpop_fail", o_fail_cnt, 0);
        do_clear();

        // Orphan RX, then bypass
        drive(1'b0, '0, 1'b1, 8'h11);
        check("orphan_flag", o_err_orphan, 1);
        check("orphan_no_match", o_match, 0);
        check("orphan_pass", o_pass_cnt, 0);
        check("orphan_fail", o_fail_cnt, 0);
        expect_cmp(8'h22, 8'h22, 1'b1);
        drive(1'b1, 8'h22, 1'b1, 8'h22);
        check("bypass_match", o_match, 1);
        check("bypass_pending0", o_pending, 0);
        check("bypass_state_idle", o_state, 0);
        check("bypass_pass", o_pass_cnt, 1);
        do_clear();

        // Timeout after 100 cycles with a byte pending
        drive(1'b1, 8'h7E, 1'b0, '0);
        idle(99);
        check("tmo_state_wait", o_state, 1);
        check("tmo_not_yet", o_err_timeout, 0);
        idle(1);
        check("tmo_state_stall", o_state, 2);
        check("tmo_flag", o_err_timeout, 1);
        check("tmo_pending1", o_pending, 1);
        expect_cmp(8'h7E, 8'h7E, 1'b1);
        drive(1'b0, '0, 1'b1, 8'h7E);
        check("tmo_late_match", o_match, 1);
        check("tmo_state_idle", o_state, 0);
        check("tmo_flag_sticky", o_err_timeout, 1);

        // Reset mid-operation discards queued words
        drive(1'b1, 8'h01, 1'b0, '0);
        drive(1'b1, 8'h02, 1'b0, '0);
        check("midrst_pending2", o_pending, 2);
        aresetn = 1'b0;
        #2;
        check_all_zero("midrst");
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // Clear beats a same-cycle RX
        drive(1'b1, 8'h5A, 1'b0, '0);
        expect_cmp(8'h5A, 8'h5A, 1'b1);
        drive(1'b0, '0, 1'b1, 8'h5A);
        check("preclear_pass", o_pass_cnt, 1);
        drive(1'b1, 8'h6B, 1'b0, '0);
        clear = 1'b1;
        drive(1'b0, '0, 1'b1, 8'h6B);
        clear = 1'b0;
        check_all_zero("clear_rx");

        idle(3);
        check("sb_queue_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
